// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: widths, PC step and the buffered fetch entry.
package inst_fetch_unit_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer: DEPTH entries of {pc, inst}, push/pop/flush, occupancy count.
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, response buffering, redirect flush.
// Optional stall_cycles counter enabled by defining FETCH_STALL_CNT_EN.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    in_flight;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              fire;
  logic              drop;
  logic              push;
  logic              pop;
  logic              redirect_q;

  // Requests in flight plus buffered words never exceed FIFO_DEPTH, so push cannot overflow.
  assign in_flight = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req  = !reset && !redirect_valid && (in_flight < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;
  assign fire      = imem_req && imem_gnt;

  assign drop = imem_rvalid && (drop_cnt != '0);
  assign push = imem_rvalid && !drop && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  assign push_entry = '{pc: resp_pc, inst: imem_rdata};

  assign inst_valid = !reset && (fifo_count != '0);
  assign inst_data  = inst_valid ? head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Every response still owed, including ones already marked for drop, becomes stale.
      fetch_pc    <= word_align(redirect_pc);
      resp_pc     <= word_align(redirect_pc);
      outstanding <= outstanding - CNT_W'(imem_rvalid);
      drop_cnt    <= outstanding - CNT_W'(imem_rvalid);
    end else begin
      if (fire) fetch_pc <= fetch_pc + PC_STEP;
      if (push) resp_pc  <= resp_pc + PC_STEP;
      if (drop) drop_cnt <= drop_cnt - CNT_W'(1);
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(imem_rvalid);
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (inst_ready && !inst_valid && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    redirect_q <= reset ? 1'b0 : redirect_valid;
    if (!reset) begin
      assert (!(imem_rvalid && (outstanding == '0)));
      assert (!(redirect_valid && redirect_q));
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit against a per-request reference model.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: each granted request remembers its own address and whether a redirect made it stale.
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  req_t        mem_q[$];
  ent_t        fq[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_stall = '0;
  bit          last_redir = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model at the edge.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit gnt, input bit rv, input bit rdy);
    bit          rv_eff;
    bit          exp_req;
    bit          exp_valid;
    logic [31:0] data;
    req_t        r;
    if (rst || last_redir) redir = 0;
    rv_eff = rv && !rst && (mem_q.size() > 0);
    data   = $urandom;
    reset = rst; redirect_valid = redir; redirect_pc = rpc;
    imem_gnt = gnt; imem_rvalid = rv_eff; imem_rdata = data; inst_ready = rdy;
    #2;
    exp_req   = !rst && !redir && ((mem_q.size() + fq.size()) < DEPTH);
    exp_valid = !rst && (fq.size() > 0);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
    chk("inst_pc", inst_pc, exp_valid ? fq[0].pc : 32'h0);
    chk("inst_data", inst_data, exp_valid ? fq[0].inst : 32'h0);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
`endif
    @(posedge clk);
    if (rst) begin
      mem_q.delete(); fq.delete(); m_pc = RESET_PC; m_stall = '0;
    end else begin
      if (rdy && !exp_valid && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (redir) begin
        if (rv_eff) void'(mem_q.pop_front());
        foreach (mem_q[i]) mem_q[i].stale = 1;
        fq.delete();
        m_pc = rpc & ~32'h3;
      end else begin
        if (exp_valid && rdy) void'(fq.pop_front());
        if (rv_eff) begin
          r = mem_q.pop_front();
          if (!r.stale) fq.push_back('{r.addr, data});
        end
        if (exp_req && gnt) begin
          mem_q.push_back('{m_pc, 0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    last_redir = redir && !rst;
    #1;
  endtask

  initial begin
    int first_valid;
    @(posedge clk); #1;
    repeat (2) step(1, 0, 0, 0, 0, 0);

    // Streaming: grant always, response one cycle later, decode always ready.
    first_valid = -1;
    for (int i = 0; i < 10; i++) begin
      if (first_valid < 0 && inst_valid === 1'b1) first_valid = i;
      step(0, 0, 0, 1, 1, 1);
    end
    chk("first_valid_cycle", 32'(first_valid), 32'd2);

    // Backpressure fills the buffer and stops issue; release drains it.
    repeat (5) step(0, 0, 0, 1, 1, 0);
    repeat (6) step(0, 0, 0, 1, 1, 1);

    // Redirect with requests outstanding and a word buffered.
    repeat (3) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 1, 32'h0000_0043, 1, 0, 0);
    repeat (8) step(0, 0, 0, 1, 1, 1);

    // Withheld grant keeps the request stable.
    repeat (5) step(0, 0, 0, 0, 1, 1);
    repeat (4) step(0, 0, 0, 1, 1, 1);

    // Address wrap at the top of the space.
    step(0, 1, 32'hFFFF_FFF9, 1, 1, 1);
    repeat (8) step(0, 0, 0, 1, 1, 1);

    // Reset with fetches in flight, then back-to-back redirect pulses.
    repeat (2) step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1);
    repeat (4) step(0, 0, 0, 1, 1, 1);
    step(0, 1, 32'h0000_1000, 1, 1, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 32'h0000_2002, 1, 1, 1);
    repeat (6) step(0, 0, 0, 1, 1, 1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      bit          rs;
      bit          rd;
      logic [31:0] tgt;
      rs  = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      step(rs, rd, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
